// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the multi-cycle memory sequencer.
package mem_seq_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned CNT_W           = 16;
    localparam int unsigned ACC_W           = 2;
    localparam int unsigned RET_W           = 32;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_DATA   = 3'd3,
        S_COMMIT = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    typedef logic [ACC_W-1:0] acc_t;

    localparam acc_t ACC_NONE = 2'd0;
    localparam acc_t ACC_RD   = 2'd1;
    localparam acc_t ACC_WR   = 2'd2;

endpackage

// File: rtl/mem_seq_timeout.sv
// Memory wait counter: counts stalled request cycles and flags the last allowed one.
module mem_seq_timeout
    import mem_seq_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    // Asserted on the stall cycle that would bring the count up to LIMIT.
    assign expired_c = inc && !clear && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_seq_ctrl.sv
// Multi-cycle fetch/decode/data/commit sequencer sharing one single-port memory.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    input  logic              dm_re,
    input  logic [BE_W-1:0]   dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              commit,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic [BE_W-1:0]   mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err,
    output logic [RET_W-1:0]  retired
);

    state_t state, state_next;
    acc_t   acc_q, acc_next;
    logic   instr_ld_c, rdata_ld_c, err_set_c;
    logic   req_c, stall_c, clear_c, expired_c;

    // Request is a pure state decode, squashed while reset is held.
    assign req_c   = ((state == S_FETCH) || (state == S_DATA)) && !rst;
    assign stall_c = req_c && !mem_ready;
    assign clear_c = (state_next != state) &&
                     ((state_next == S_FETCH) || (state_next == S_DATA));

    mem_seq_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_c),
        .inc       (stall_c),
        .expired_c (expired_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RST;
            acc_q <= ACC_NONE;
        end else begin
            state <= state_next;
            acc_q <= acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr    <= '0;
            dm_rdata <= '0;
            retired  <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (instr_ld_c) instr    <= mem_rdata;
            if (rdata_ld_c) dm_rdata <= mem_rdata;
            if (commit)     retired  <= retired + RET_W'(1);
            if (err_set_c)  bus_err  <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc_q;
        instr_ld_c = 1'b0;
        rdata_ld_c = 1'b0;
        err_set_c  = 1'b0;
        commit     = 1'b0;
        mem_req    = req_c;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = '0;
        mem_wdata  = '0;

        case (state)
            S_RST: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_addr = pc;
                mem_re   = 1'b1;
                if (mem_ready) begin
                    instr_ld_c = 1'b1;
                    state_next = S_DECODE;
                end else if (expired_c) begin
                    err_set_c  = 1'b1;
                    state_next = S_ERR;
                end
            end
            S_DECODE: begin
                // Stores win over loads when both decode bits are set.
                if (dm_we != '0) begin
                    acc_next   = ACC_WR;
                    state_next = S_DATA;
                end else if (dm_re) begin
                    acc_next   = ACC_RD;
                    state_next = S_DATA;
                end else begin
                    acc_next   = ACC_NONE;
                    state_next = S_COMMIT;
                end
            end
            S_DATA: begin
                mem_addr = dm_addr;
                if (acc_q == ACC_WR) begin
                    mem_we    = dm_we;
                    mem_wdata = dm_wdata;
                end else begin
                    mem_re = 1'b1;
                end
                if (mem_ready) begin
                    rdata_ld_c = (acc_q == ACC_RD);
                    state_next = S_COMMIT;
                end else if (expired_c) begin
                    err_set_c  = 1'b1;
                    state_next = S_ERR;
                end
            end
            S_COMMIT: begin
                commit     = 1'b1;
                state_next = S_FETCH;
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_RST;
            end
        endcase

        if (rst) begin
            commit    = 1'b0;
            mem_addr  = '0;
            mem_re    = 1'b0;
            mem_we    = '0;
            mem_wdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl: slot-scheduled expectations plus literal pins.
module tb_mem_seq_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, instr, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, retired;
    logic        dm_re, commit, mem_req, mem_re, mem_ready, bus_err;
    logic [3:0]  dm_we, mem_we;

    always #5 clk = ~clk;

    mem_seq_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TMO),
        .BE_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .instr     (instr),
        .dm_re     (dm_re),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .commit    (commit),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err),
        .retired   (retired)
    );

    int n_pass  = 0;
    int n_total = 0;
    int slot    = 0;
    int last_commit_slot = -1;
    bit chk_en  = 1'b0;

    // Expected bus-side outputs for the current slot.
    logic        e_req = 1'b0, e_re = 1'b0, e_commit = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0;
    logic [3:0]  e_we = '0;
    // Architectural state the model tracks.
    logic [31:0] m_instr = '0, m_rdata = '0, m_retired = '0;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s slot %0d: got %h expected %h", name, slot, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req",   32'(mem_req),   32'(e_req));
            chk("mem_addr",  mem_addr,       e_addr);
            chk("mem_re",    32'(mem_re),    32'(e_re));
            chk("mem_we",    32'(mem_we),    32'(e_we));
            chk("mem_wdata", mem_wdata,      e_wdata);
            chk("commit",    32'(commit),    32'(e_commit));
            chk("instr",     instr,          m_instr);
            chk("dm_rdata",  dm_rdata,       m_rdata);
            chk("retired",   retired,        m_retired);
            chk("bus_err",   32'(bus_err),   32'(m_err));
            if (commit === 1'b1) last_commit_slot = slot;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        slot++;
    endtask

    task automatic expect_bus(input logic req, input logic [31:0] addr, input logic re,
                              input logic [3:0] we, input logic [31:0] wd, input logic cm);
        e_req = req; e_addr = addr; e_re = re; e_we = we; e_wdata = wd; e_commit = cm;
    endtask

    task automatic clear_decode();
        dm_re = 1'b0; dm_we = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    // One instruction: fw fetch stalls, decode, optional access with dw stalls, commit.
    task automatic run_instr(input logic [31:0] pcv, input logic [31:0] iword, input int fw,
                             input logic re, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int dw);
        pc = pcv;
        for (int i = 0; i <= fw; i++) begin
            mem_ready = (i == fw);
            mem_rdata = (i == fw) ? iword : (32'hBAD0_0000 + 32'(i));
            expect_bus(1'b1, pcv, 1'b1, 4'h0, 32'h0, 1'b0);
            next_cycle();
        end
        m_instr = iword;
        dm_re = re; dm_we = be; dm_addr = addr; dm_wdata = wd;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        expect_bus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        next_cycle();
        if (re || (be != 4'h0)) begin
            for (int j = 0; j <= dw; j++) begin
                mem_ready = (j == dw);
                mem_rdata = rd;
                if (be != 4'h0) expect_bus(1'b1, addr, 1'b0, be, wd, 1'b0);
                else            expect_bus(1'b1, addr, 1'b1, 4'h0, 32'h0, 1'b0);
                next_cycle();
            end
            if (be == 4'h0) m_rdata = rd;
        end
        clear_decode();
        mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        expect_bus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        next_cycle();
        m_retired = m_retired + 32'd1;
    endtask

    // Hold rst for n slots; the first slot still shows pre-reset register values.
    task automatic do_reset(input int n, input logic rdy, input logic [31:0] rd);
        rst = 1'b1;
        clear_decode();
        mem_ready = rdy; mem_rdata = rd;
        expect_bus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            m_instr = '0; m_rdata = '0; m_retired = '0; m_err = 1'b0;
        end
        rst = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        next_cycle();
    endtask

    initial begin
        int s0;
        rst = 1'b1; pc = '0; mem_ready = 1'b0; mem_rdata = '0;
        clear_decode();
        next_cycle();
        chk_en = 1'b1;
        do_reset(3, 1'b0, 32'h0);

        // ADD, zero-wait fetch.
        s0 = slot;
        run_instr(32'h0, 32'h0020_81B3, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
        chk("add_instr",   instr,   32'h0020_81B3);
        chk("add_retired", retired, 32'd1);
        chk("add_latency", 32'(last_commit_slot - s0 + 1), 32'd3);

        // LW with two data wait states.
        s0 = slot;
        run_instr(32'h4, 32'h1000_2283, 0, 1'b1, 4'h0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
        chk("lw_rdata",   dm_rdata, 32'hDEAD_BEEF);
        chk("lw_latency", 32'(last_commit_slot - s0 + 1), 32'd6);

        // SB with dm_re also set: write wins, load data untouched.
        run_instr(32'h8, 32'h00B4_0123, 1, 1'b1, 4'b0100, 32'h202, 32'h00AB_0000,
                  32'h5555_5555, 1);
        chk("sb_rdata", dm_rdata, 32'hDEAD_BEEF);

        // Longest legal stalls in both fetch and data phases.
        run_instr(32'hC, 32'h0041_2303, 3, 1'b1, 4'h0, 32'h104, 32'h0, 32'hCAFE_F00D, 3);
        run_instr(32'h10, 32'h0010_0093, 2, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
        chk("seq_retired", retired, 32'd5);

        // Fetch timeout: TMO stalled cycles, then frozen error state.
        pc = 32'h40;
        for (int i = 0; i < int'(TMO); i++) begin
            mem_ready = 1'b0; mem_rdata = 32'h1111_1111;
            expect_bus(1'b1, 32'h40, 1'b1, 4'h0, 32'h0, 1'b0);
            next_cycle();
        end
        m_err = 1'b1;
        chk("tmo_bus_err", 32'(bus_err), 32'd1);
        for (int k = 0; k < 3; k++) begin
            mem_ready = k[0]; mem_rdata = 32'h2222_2222;
            expect_bus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
            next_cycle();
        end
        chk("tmo_retired", retired, 32'd5);
        do_reset(2, 1'b0, 32'h0);

        // Reset while a load is stalled; the ready arriving with rst is dropped.
        run_instr(32'h0, 32'h0020_81B3, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
        pc = 32'h4;
        mem_ready = 1'b1; mem_rdata = 32'h0000_2283;
        expect_bus(1'b1, 32'h4, 1'b1, 4'h0, 32'h0, 1'b0);
        next_cycle();
        m_instr = 32'h0000_2283;
        dm_re = 1'b1; dm_addr = 32'h300;
        expect_bus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        next_cycle();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        expect_bus(1'b1, 32'h300, 1'b1, 4'h0, 32'h0, 1'b0);
        next_cycle();
        do_reset(2, 1'b1, 32'h1234_5678);
        chk("rst_retired", retired, 32'd0);
        chk("rst_rdata",   dm_rdata, 32'd0);

        run_instr(32'h0, 32'h0030_8233, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
        chk("resume_instr",   instr,   32'h0030_8233);
        chk("resume_retired", retired, 32'd1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
